uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART transmitter between N_REQ byte producers. Each requester offers a byte over a valid/ready handshake. The arbiter grants one requester, launches the transmitter with a one-cycle start pulse, then holds off all other requesters until the transmitter reports frame completion or a watchdog expires. It sits between the protocol/command logic and the UART TX core, and runs on the same baud-tick clock domain.

---
 rtl/uart_tx_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one UART transmitter between N_REQ byte
//   producers. The winning requester's byte is latched at the accept edge.
//   The TX core gets a one-cycle start pulse, and every other requester is
//   held off until the core reports completion or the watchdog expires.
//
// Ports:
//   clk           system clock (baud-tick domain)
//   rst           synchronous active-high reset
//   req_valid     per-requester byte valid
//   req_data      packed bytes, requester i at [i*DBIT +: DBIT]
//   req_ready     per-requester accept (combinational, one-hot or zero)
//   tx_start      one-cycle launch pulse to the TX core
//   tx_din        byte to the TX core, stable from launch to completion
//   tx_done_tick  completion pulse from the TX core
//   grant_id      index of the current or last granted requester
//   busy          high whenever the arbiter is not idle
//   err_timeout   sticky watchdog error flag
//   err_clr       clears err_timeout
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DBIT-1:0]    req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [DBIT-1:0]          tx_din,
  input  logic                     tx_done_tick,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  localparam int IW = $clog2(N_REQ);
  // The timer only has to reach TIMEOUT-1; a disabled watchdog still needs one bit.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};
  localparam logic [IW-1:0] ID_LAST = IW'(N_REQ - 1);
  localparam bit            WD_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [IW-1:0]     rr_ptr_r;
  logic [IW-1:0]     grant_id_r;
  logic [IW-1:0]     winner_s;
  logic              found_s;
  logic [TW-1:0]     timer_r;
  logic              timeout_hit_s;
  logic              tx_start_r;
  logic [DBIT-1:0]   tx_din_r;
  logic              busy_r;
  logic              err_timeout_r;

  // Requester index at offset k from base, wrapping modulo N_REQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_REQ;
    return IW'(s);
  endfunction

  // Successor of a requester index, wrapping modulo N_REQ.
  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    logic [IW-1:0] n;
    if (id == ID_LAST) begin
      n = {IW{1'b0}};
    end else begin
      n = id + IW'(1);
    end
    return n;
  endfunction

  assign tx_start    = tx_start_r;
  assign tx_din      = tx_din_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;
  assign err_timeout = err_timeout_r;

  assign timeout_hit_s = WD_EN && (timer_r == T_LAST);

  // Round-robin search: scanning offsets high to low leaves the closest valid requester.
  always_comb begin
    winner_s = {IW{1'b0}};
    found_s  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(rr_ptr_r, k)]) begin
        winner_s = rr_idx(rr_ptr_r, k);
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Ready is offered only to the winner, and only while idle.
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    if ((state_r == ST_IDLE) && found_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  // Next-state logic; done pulses outside WAIT are deliberately ignored.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_next_s = ST_LAUNCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick || timeout_hit_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, registered outputs, watchdog timer and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r      <= {IW{1'b0}};
      grant_id_r    <= {IW{1'b0}};
      tx_din_r      <= {DBIT{1'b0}};
      tx_start_r    <= 1'b0;
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
      timer_r       <= {TW{1'b0}};
    end else begin
      tx_start_r <= (state_next_s == ST_LAUNCH);
      busy_r     <= (state_next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            tx_din_r   <= req_data[int'(winner_s)*DBIT +: DBIT];
            grant_id_r <= winner_s;
          end
        end
        ST_LAUNCH: begin
          timer_r <= {TW{1'b0}};
        end
        ST_WAIT: begin
          // Saturate so a disabled watchdog never wraps.
          if (timer_r != {TW{1'b1}}) begin
            timer_r <= timer_r + TW'(1);
          end
          if (tx_done_tick || timeout_hit_s) begin
            rr_ptr_r <= next_id(grant_id_r);
          end
        end
        default: begin
          timer_r <= {TW{1'b0}};
        end
      endcase
      // Completion beats the watchdog; a new error beats a clear.
      if ((state_r == ST_WAIT) && !tx_done_tick && timeout_hit_s) begin
        err_timeout_r <= 1'b1;
      end else if (err_clr) begin
        err_timeout_r <= 1'b0;
      end
    end
  end

endmodule
